// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use stall, branch flush and EX forwarding control
// for the 5-stage LEGv8 pipeline. Optional macro: HAZARD_PERF_CNT_EN.
//
// Ports:
//   CLOCK, RESET            rising-edge clock, async active-low reset
//   id_rs1/2, id_rs1/2_used ID-stage source registers and use flags
//   ex_rs1/2                EX-stage source registers
//   idex_memread/writereg   load in EX and its destination
//   exmem_/memwb_regwrite,
//   exmem_/memwb_writereg   producers for forwarding
//   branch_taken            branch resolved taken in MEM
//   pc_write_en, ifid_write_en, idex_bubble   stall controls
//   ifid_flush, idex_flush, exmem_flush       branch flush controls
//   forward_a, forward_b    ALU operand selects (10=EXMEM, 01=MEMWB, 00=reg)
//   busy                    FSM is in STALL
//   stall_count, flush_count  saturating counters (HAZARD_PERF_CNT_EN only)
module pipeline_hazard_ctrl #(
   parameter int STALL_CYCLES = 1,
   parameter int CNT_WIDTH    = 32,
   parameter int ZERO_REG     = 31
) (
   input  logic       CLOCK,
   input  logic       RESET,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_rs1_used,
   input  logic       id_rs2_used,
   input  logic [4:0] ex_rs1,
   input  logic [4:0] ex_rs2,
   input  logic       idex_memread,
   input  logic [4:0] idex_writereg,
   input  logic       exmem_regwrite,
   input  logic [4:0] exmem_writereg,
   input  logic       memwb_regwrite,
   input  logic [4:0] memwb_writereg,
   input  logic       branch_taken,
   output logic       pc_write_en,
   output logic       ifid_write_en,
   output logic       idex_bubble,
   output logic       ifid_flush,
   output logic       idex_flush,
   output logic       exmem_flush,
   output logic [1:0] forward_a,
   output logic [1:0] forward_b,
   output logic       busy
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0] stall_count,
   output logic [CNT_WIDTH-1:0] flush_count
`endif
);

   localparam logic [4:0] LP_ZR   = 5'(ZERO_REG);
   localparam logic [3:0] LP_LOAD = 4'(STALL_CYCLES - 1);

   typedef enum logic {ST_RUN, ST_STALL} state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_cnt;
   logic [3:0] w_cnt_nxt;
   logic       w_hazard;
   logic       w_rs1_hit;
   logic       w_rs2_hit;
   logic       w_stall;

   assign w_rs1_hit = id_rs1_used & (id_rs1 == idex_writereg);
   assign w_rs2_hit = id_rs2_used & (id_rs2 == idex_writereg);
   assign w_hazard  = idex_memread & (idex_writereg != LP_ZR)
                    & (w_rs1_hit | w_rs2_hit);

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         r_state <= ST_RUN;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // A taken branch cancels any pending stall.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (branch_taken) begin
         w_state_nxt = ST_RUN;
         w_cnt_nxt   = '0;
      end else begin
         unique case (r_state)
            ST_RUN: begin
               if (w_hazard && (STALL_CYCLES > 1)) begin
                  w_state_nxt = ST_STALL;
                  w_cnt_nxt   = LP_LOAD;
               end
            end
            ST_STALL: begin
               if (r_cnt <= 4'd1) begin
                  w_state_nxt = ST_RUN;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt - 4'd1;
               end
            end
            default: begin
               w_state_nxt = ST_RUN;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   function automatic logic [1:0] fwd_sel(
      input logic [4:0] rs,
      input logic       em_we,
      input logic [4:0] em_rd,
      input logic       mw_we,
      input logic [4:0] mw_rd
   );
      if (em_we && (em_rd != LP_ZR) && (em_rd == rs))
         return 2'b10;
      else if (mw_we && (mw_rd != LP_ZR) && (mw_rd == rs))
         return 2'b01;
      else
         return 2'b00;
   endfunction

   assign w_stall = (r_state == ST_STALL) | w_hazard;

   // Outputs are held at their idle values while reset is asserted.
   always_comb begin
      pc_write_en   = 1'b1;
      ifid_write_en = 1'b1;
      idex_bubble   = 1'b0;
      ifid_flush    = 1'b0;
      idex_flush    = 1'b0;
      exmem_flush   = 1'b0;
      busy          = 1'b0;
      forward_a     = 2'b00;
      forward_b     = 2'b00;
      if (RESET) begin
         busy      = (r_state == ST_STALL);
         forward_a = fwd_sel(ex_rs1, exmem_regwrite, exmem_writereg,
                             memwb_regwrite, memwb_writereg);
         forward_b = fwd_sel(ex_rs2, exmem_regwrite, exmem_writereg,
                             memwb_regwrite, memwb_writereg);
         if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
         end else if (w_stall) begin
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            idex_bubble   = 1'b1;
         end
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_WIDTH-1:0] r_stall_cnt;
   logic [CNT_WIDTH-1:0] r_flush_cnt;

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (idex_bubble && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 1'b1;
         if (branch_taken && (r_flush_cnt != '1))
            r_flush_cnt <= r_flush_cnt + 1'b1;
      end
   end

   assign stall_count = r_stall_cnt;
   assign flush_count = r_flush_cnt;
`endif

endmodule
